// File: rtl/handle_client_ctrl.sv
// handle_client_ctrl: turns ALLOC/QUERY/FREE requests into handle-unit READ/WRITE command cycles.
// Optional build macro HANDLE_CLIENT_VERIFY_EN adds a read-back check of each new mapping.
module handle_client_ctrl #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned HNDL_W = 15
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_kind,
    input  logic [ADDR_W-1:0] req_base,
    input  logic [HNDL_W-1:0] req_handle,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [HNDL_W-1:0] resp_handle,
    output logic [ADDR_W-1:0] resp_addr,
    output logic              resp_err,
    output logic [2:0]        o_op,
    output logic [ADDR_W-1:0] o_address,
    output logic [ADDR_W-1:0] o_data,
    input  logic [ADDR_W-1:0] i_data
);

    localparam int unsigned MAP_W = ADDR_W - HNDL_W;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_READ  = 3'd1;
    localparam logic [2:0] OP_WRITE = 3'd2;

    localparam logic [1:0] K_ALLOC = 2'd0;
    localparam logic [1:0] K_QUERY = 2'd1;
    localparam logic [1:0] K_FREE  = 2'd2;

    localparam logic [HNDL_W-1:0] ID_RSVD = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_GET, S_MAP, S_RD, S_FREE, S_RESP
`ifdef HANDLE_CLIENT_VERIFY_EN
        , S_VERIFY
`endif
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] base_q;
    logic [HNDL_W-1:0] hndl_q;
    logic [HNDL_W-1:0] got_id;
    logic              pre_err;

    // Handle-op window address for a given id.
    function automatic logic [ADDR_W-1:0] op_addr(input logic [HNDL_W-1:0] id);
        logic [ADDR_W-1:0] a;
        a                     = '0;
        a[ADDR_W-1]           = 1'b1;
        a[ADDR_W-2 -: HNDL_W] = '1;
        a[HNDL_W-1:0]         = id;
        return a;
    endfunction

    assign got_id = i_data[HNDL_W-1:0];

    // Requests rejected before any bus cycle is issued.
    always_comb begin
        pre_err = 1'b0;
        case (req_kind)
            K_ALLOC: pre_err = (req_base == '0) || (req_base[ADDR_W-1 -: HNDL_W] != '0);
            K_QUERY,
            K_FREE:  pre_err = (req_handle == ID_RSVD);
            default: pre_err = 1'b1;
        endcase
    end

`ifndef HANDLE_CLIENT_VERIFY_EN
    logic unused_data;
    assign unused_data = ^i_data[ADDR_W-1:MAP_W];
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state       <= S_IDLE;
            req_ready   <= 1'b0;
            resp_valid  <= 1'b0;
            resp_handle <= '0;
            resp_addr   <= '0;
            resp_err    <= 1'b0;
            o_op        <= OP_NOP;
            o_address   <= '0;
            o_data      <= '0;
            base_q      <= '0;
            hndl_q      <= '0;
        end else begin
            // Every command lasts one cycle; the bus idles unless a state drives it below.
            o_op      <= OP_NOP;
            o_address <= '0;
            o_data    <= '0;
            case (state)
                S_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready   <= 1'b0;
                        base_q      <= req_base;
                        hndl_q      <= req_handle;
                        resp_handle <= (req_kind == K_ALLOC) ? '0 : req_handle;
                        resp_addr   <= '0;
                        resp_err    <= 1'b0;
                        if (pre_err) begin
                            resp_err <= 1'b1;
                            state    <= S_RESP;
                        end else if (req_kind == K_ALLOC) begin
                            o_op      <= OP_READ;
                            o_address <= op_addr(ID_RSVD);
                            state     <= S_GET;
                        end else if (req_kind == K_QUERY) begin
                            o_op      <= OP_READ;
                            o_address <= op_addr(req_handle);
                            state     <= S_RD;
                        end else begin
                            o_op      <= OP_WRITE;
                            o_address <= op_addr(req_handle);
                            state     <= S_FREE;
                        end
                    end
                end
                S_GET: begin
                    hndl_q      <= got_id;
                    resp_handle <= got_id;
                    if (got_id == ID_RSVD) begin
                        resp_err   <= 1'b1;
                        resp_valid <= 1'b1;
                        state      <= S_RESP;
                    end else begin
                        o_op      <= OP_WRITE;
                        o_address <= op_addr(got_id);
                        o_data    <= base_q;
                        state     <= S_MAP;
                    end
                end
                S_MAP: begin
`ifdef HANDLE_CLIENT_VERIFY_EN
                    o_op      <= OP_READ;
                    o_address <= op_addr(hndl_q);
                    state     <= S_VERIFY;
`else
                    resp_valid <= 1'b1;
                    state      <= S_RESP;
`endif
                end
`ifdef HANDLE_CLIENT_VERIFY_EN
                S_VERIFY: begin
                    // A mapping that does not read back is released before reporting the error.
                    if (i_data != base_q) begin
                        o_op      <= OP_WRITE;
                        o_address <= op_addr(hndl_q);
                        resp_err  <= 1'b1;
                        state     <= S_FREE;
                    end else begin
                        resp_valid <= 1'b1;
                        state      <= S_RESP;
                    end
                end
`endif
                S_RD: begin
                    resp_addr  <= ADDR_W'(i_data[MAP_W-1:0]);
                    resp_valid <= 1'b1;
                    state      <= S_RESP;
                end
                S_FREE: begin
                    resp_valid <= 1'b1;
                    state      <= S_RESP;
                end
                S_RESP: begin
                    // Precheck errors arrive here with resp_valid still low.
                    if (!resp_valid) begin
                        resp_valid <= 1'b1;
                    end else if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
